// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller: a small byte FIFO feeds a timed
// RS/DB/E sequencer with an optional power-up init and pollable status.
module lcd_hd44780_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_PWRUP     = 750000,
  parameter int T_SETUP     = 4,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 80000,
  parameter bit INIT_EN     = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_wr_vld,
  output logic                          o_wr_rdy,
  input  logic                          i_wr_rs,
  input  logic [7:0]                    i_wr_data,
  input  logic                          i_on,
  output logic [7:0]                    o_lcd_data,
  output logic                          o_lcd_rs,
  output logic                          o_lcd_rw,
  output logic                          o_lcd_en,
  output logic                          o_lcd_on,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_init_done
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;
  localparam int M1    = (T_PWRUP > T_EXEC_LONG) ? T_PWRUP : T_EXEC_LONG;
  localparam int M2    = (T_EXEC > T_EN) ? T_EXEC : T_EN;
  localparam int M3    = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int M4    = (M1 > M2) ? M1 : M2;
  localparam int T_MAX = (M4 > M3) ? M4 : M3;
  localparam int CW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_EN_HIGH, S_HOLD, S_EXEC_WAIT
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      idx_q;
  logic            in_init_q;
  logic [7:0]      data_q;
  logic            rs_q, en_q, on_q, done_q, rdy_q;
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [8:0]      head;
  logic            push, pop, exec_long;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign head      = mem_q[rd_ptr_q];
  assign push      = i_wr_vld & rdy_q;
  assign pop       = (state_q == S_IDLE) && (level_q != '0);
  // Clear display / return home are the only slow instructions.
  assign exec_long = !rs_q && (data_q[7:2] == 6'd0);

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (!push && pop)
      level_d = level_q - LW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {i_wr_rs, i_wr_data};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdy_q    <= 1'b0;
      on_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      rdy_q   <= (level_d < LW'(FIFO_DEPTH));
      on_q    <= i_on;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_PWRUP;
      cnt_q     <= '0;
      idx_q     <= '0;
      in_init_q <= 1'b0;
      data_q    <= '0;
      rs_q      <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_PWRUP: begin
          if (!INIT_EN) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (cnt_q == CW'(T_PWRUP - 1)) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_INIT: begin
          data_q    <= init_byte(idx_q);
          rs_q      <= 1'b0;
          in_init_q <= 1'b1;
          cnt_q     <= CW'(T_SETUP - 1);
          state_q   <= S_SETUP;
        end
        S_IDLE: begin
          if (level_q != '0) begin
            data_q    <= head[7:0];
            rs_q      <= head[8];
            in_init_q <= 1'b0;
            cnt_q     <= CW'(T_SETUP - 1);
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            cnt_q   <= CW'(T_EN - 1);
            state_q <= S_EN_HIGH;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_EN_HIGH: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b0;
            cnt_q   <= CW'(T_HOLD - 1);
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            cnt_q   <= exec_long ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
            state_q <= S_EXEC_WAIT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_EXEC_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (in_init_q && idx_q != 2'd3) begin
            idx_q   <= idx_q + 2'd1;
            state_q <= S_INIT;
          end else begin
            in_init_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_PWRUP;
      endcase
    end
  end

  assign o_wr_rdy    = rdy_q;
  assign o_lcd_data  = data_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_on    = on_q;
  assign o_busy      = (state_q != S_IDLE) || (level_q != '0);
  assign o_level     = level_q;
  assign o_init_done = done_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl: vector table, hand-written corner
// sequences and random pushes scored against a byte-order / timing-rule model.
module tb_lcd_hd44780_ctrl;

  localparam int DEPTH = 4;
  localparam int TPW   = 20;
  localparam int TSU   = 2;
  localparam int TEN   = 4;
  localparam int THD   = 2;
  localparam int TEX   = 10;
  localparam int TEXL  = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_vld = 1'b0;
  logic       wr_rdy;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       on_in = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, busy, init_done;
  logic [2:0] level;

  lcd_hd44780_ctrl #(
    .FIFO_DEPTH(DEPTH), .T_PWRUP(TPW), .T_SETUP(TSU), .T_EN(TEN),
    .T_HOLD(THD), .T_EXEC(TEX), .T_EXEC_LONG(TEXL), .INIT_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_wr_vld(wr_vld), .o_wr_rdy(wr_rdy),
    .i_wr_rs(wr_rs), .i_wr_data(wr_data), .i_on(on_in),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_en(lcd_en), .o_lcd_on(lcd_on), .o_busy(busy),
    .o_level(level), .o_init_done(init_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int m_rise[8];
  int m_fall[8];
  int m_np, m_idle, m_done;
  logic [8:0] m_d1;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       exp_long;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int req_min);
    total++;
    if (act < req_min) begin
      bad++;
      $display("FAIL %s: got %0d required at least %0d", name, act, req_min);
    end
  endtask

  function automatic int wait_of(input logic [8:0] b);
    return (!b[8] && b[7:2] == 6'd0) ? TEXL : TEX;
  endfunction

  // Bus monitor: records every EN pulse and checks the per-pulse timing rules.
  initial begin : mon
    int mc = 0;
    int rise = 0;
    int last_fall = -1;
    logic en_p = 1'b0;
    logic [8:0] cur = '0;
    logic [8:0] prev = '0;
    logic [8:0] hd[16];
    forever begin
      @(negedge clk);
      mc++;
      if (!rst_n) begin
        en_p = 1'b0;
        last_fall = -1;
      end else begin
        hd[mc % 16] = {lcd_rs, lcd_data};
        chk("rdy_vs_level", int'(wr_rdy), int'(level < 3'(DEPTH)));
        chk("rw_low", int'(lcd_rw), 0);
        if (lcd_en && !en_p) begin
          cur = {lcd_rs, lcd_data};
          rise = mc;
          obs_q.push_back(cur);
          chk("setup_stable", int'(hd[(mc - TSU) % 16]), int'(cur));
          chk("busy_during_en", int'(busy), 1);
          if (last_fall >= 0)
            chk_ge("gap", rise - last_fall, THD + wait_of(prev) + 1 + TSU);
        end
        if (!lcd_en && en_p) begin
          chk("en_width", mc - rise, TEN);
          chk("hold_stable", int'({lcd_rs, lcd_data}), int'(cur));
          last_fall = mc;
          prev = cur;
        end
        en_p = lcd_en;
      end
    end
  end

  task automatic measure(input int npulse, input int budget);
    int n = 0;
    int np = 0;
    logic en_p = 1'b0;
    m_idle = -1;
    m_done = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (n == 1) m_d1 = {lcd_rs, lcd_data};
      if (lcd_en && !en_p && np < 8) m_rise[np] = n;
      if (!lcd_en && en_p && np < 8) begin
        m_fall[np] = n;
        np++;
      end
      en_p = lcd_en;
      if (init_done && m_done < 0) m_done = n;
      if (!busy && np >= npulse) begin
        m_idle = n;
        break;
      end
    end
    m_np = np;
    chk("measure_finished", int'(m_idle >= 0), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic push1(input logic rs, input logic [7:0] d);
    chk("rdy_before_push", int'(wr_rdy), 1);
    wr_vld = 1'b1;
    wr_rs = rs;
    wr_data = d;
    if (wr_rdy) exp_q.push_back({rs, d});
    @(negedge clk);
    wr_vld = 1'b0;
  endtask

  task automatic check_sb();
    logic [8:0] o, e;
    chk("sb_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      $display("lcd byte: rs=%0d data=0x%02h expected rs=%0d data=0x%02h", o[8], o[7:0], e[8], e[7:0]);
      chk("sb_byte", int'(o), int'(e));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic init_seq();
    logic [8:0] ib[4];
    int t;
    ib[0] = 9'h038; ib[1] = 9'h00C; ib[2] = 9'h001; ib[3] = 9'h006;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(ib[i]);
    measure(4, 1000);
    t = TPW;
    for (int i = 0; i < 4; i++) t += 1 + TSU + TEN + THD + wait_of(ib[i]);
    chk("init_pulses", m_np, 4);
    chk("init_first_rise", m_rise[0], TPW + 1 + TSU);
    chk("init_done_time", m_done, t);
    chk("init_idle_time", m_idle, t);
    $display("init: first_rise=%0d done=%0d", m_rise[0], m_done);
  endtask

  initial begin
    int n;
    logic rs_r;
    logic [7:0] d_r;
    vecs[0] = '{1'b1, 8'h41, 1'b0};
    vecs[1] = '{1'b0, 8'h01, 1'b1};
    vecs[2] = '{1'b0, 8'h03, 1'b1};
    vecs[3] = '{1'b0, 8'h04, 1'b0};
    vecs[4] = '{1'b1, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 8'h02, 1'b1};
    vecs[6] = '{1'b1, 8'h03, 1'b0};
    vecs[7] = '{1'b0, 8'hFC, 1'b0};

    on_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_on", int'(lcd_on), 0);
    chk("rst_done", int'(init_done), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_rdy", int'(wr_rdy), 0);
    chk("rst_busy", int'(busy), 1);
    on_in = 1'b0;

    init_seq();
    check_sb();

    foreach (vecs[i]) begin
      push1(vecs[i].rs, vecs[i].data);
      measure(1, 200);
      chk("vec_first_data", int'(m_d1), int'({vecs[i].rs, vecs[i].data}));
      chk("vec_rise", m_rise[0], 1 + TSU);
      chk("vec_width", m_fall[0] - m_rise[0], TEN);
      chk("vec_idle", m_idle, 1 + TSU + TEN + THD + (vecs[i].exp_long ? TEXL : TEX));
      $display("vec %0d: rs=%0d data=0x%02h rise=%0d idle=%0d", i, vecs[i].rs, vecs[i].data, m_rise[0], m_idle);
    end
    check_sb();

    for (int i = 0; i < 6; i++) begin
      chk("burst_rdy", int'(wr_rdy), (i < 5) ? 1 : 0);
      if (i == 5) chk("burst_level_full", int'(level), DEPTH);
      wr_vld = 1'b1;
      wr_rs = 1'b1;
      wr_data = 8'(8'h50 + i);
      if (wr_rdy) exp_q.push_back({1'b1, wr_data});
      @(negedge clk);
    end
    wr_vld = 1'b0;
    chk("burst_level_after", int'(level), DEPTH);
    chk("burst_accepted", exp_q.size(), 5);
    wait_idle(2000);
    check_sb();

    push1(1'b0, 8'h01);
    push1(1'b1, 8'h42);
    measure(2, 400);
    chk("clr_gap", m_rise[1] - m_fall[0], THD + TEXL + 1 + TSU);
    chk("data_tail", m_idle - m_fall[1], THD + TEX);
    check_sb();

    push1(1'b1, 8'h55);
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("on_en_seen", int'(lcd_en), 1);
    chk("on_before", int'(lcd_on), 0);
    on_in = 1'b1;
    @(negedge clk);
    chk("on_rise", int'(lcd_on), 1);
    on_in = 1'b0;
    @(negedge clk);
    chk("on_fall", int'(lcd_on), 0);
    wait_idle(200);
    check_sb();

    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        rs_r = 1'($urandom_range(0, 1));
        d_r = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        wr_vld = 1'b1;
        wr_rs = rs_r;
        wr_data = d_r;
        if (wr_rdy) exp_q.push_back({rs_r, d_r});
      end else begin
        wr_vld = 1'b0;
      end
      @(negedge clk);
    end
    wr_vld = 1'b0;
    wait_idle(10000);
    check_sb();

    push1(1'b0, 8'h38);
    push1(1'b1, 8'h61);
    push1(1'b1, 8'h62);
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_en_seen", int'(lcd_en), 1);
    chk("mid_level_before", int'(level), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", int'(lcd_en), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_done", int'(init_done), 0);
    chk("mid_rst_rdy", int'(wr_rdy), 0);
    chk("mid_rst_busy", int'(busy), 1);
    chk("mid_rst_data", int'(lcd_data), 0);
    chk("mid_obs", obs_q.size(), 1);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    check_sb();
    repeat (2) @(negedge clk);
    init_seq();
    check_sb();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Hardware controller for the board's HD44780-compatible character LCD. It sits between the core's LCD memory-mapped write path and the physical LCD pins.
- Command/data bytes pushed by the core are buffered in a small FIFO. Each byte is replayed to the LCD with correct setup, enable-pulse, hold and execution timing.
- An optional power-up init sequence runs after reset.
- Status outputs (busy, level, init done) are returned to the LSU read path so software can poll instead of bit-banging.

Parameters:
- FIFO_DEPTH, 4, entries in the byte FIFO; power of 2, ≥2.
- T_PWRUP, 750000, cycles to wait after reset before init (15 ms at 50 MHz).
- T_SETUP, 4, cycles RS/data are stable before EN rises.
- T_EN, 12, cycles EN is held high.
- T_HOLD, 4, cycles RS/data are held after EN falls.
- T_EXEC, 2000, execution wait for normal commands and data.
- T_EXEC_LONG, 80000, execution wait for clear/home (RS=0, data 0x00–0x03).
- INIT_EN, 1, 1 = run power-up wait plus init sequence 0x38, 0x0C, 0x01, 0x06 (all RS=0).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_wr_vld  in  1  write request from LSU.
- o_wr_rdy  out  1  FIFO can accept; write happens when i_wr_vld & o_wr_rdy at rising edge.
- i_wr_rs  in  1  0 = command, 1 = data.
- i_wr_data  in  8  byte to send.
- i_on  in  1  LCD power/backlight enable from LCD register bit 31.
- o_lcd_data  out  8  LCD DB[7:0].
- o_lcd_rs  out  1  LCD RS.
- o_lcd_rw  out  1  LCD RW; always 0 (write-only).
- o_lcd_en  out  1  LCD E.
- o_lcd_on  out  1  registered copy of i_on.
- o_busy  out  1  1 when FSM is not IDLE or FIFO is non-empty.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_init_done  out  1  set on first entry to IDLE, cleared only by reset.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - FIFO cleared; counters cleared; state = PWRUP.
  - Outputs: o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_init_done=0, o_level=0, o_wr_rdy=0, o_busy=1.
  - Asserting reset mid-transfer drops EN and all state immediately; the sequence restarts from PWRUP after release.
- o_wr_rdy is registered: it reads 1 when not in reset and o_level<FIFO_DEPTH.
  - When full, o_wr_rdy=0 even if a pop happens in the same cycle.
  - A request with i_wr_vld=1 and o_wr_rdy=0 is ignored; there is no side effect.
- Writes are accepted in every state, including PWRUP/INIT; they queue behind the init sequence.
- Simultaneous push and pop (not full): o_level is unchanged and FIFO order is preserved.
- FSM:
  - PWRUP: count T_PWRUP cycles, then go to INIT (idx=0). If INIT_EN=0, go to IDLE after 1 cycle.
  - INIT: load init byte[idx] with RS=0, then go to SETUP. After EXEC_WAIT of the 4th byte, go to IDLE.
  - IDLE: if FIFO non-empty, pop the head into the output regs (data, rs) and go to SETUP. Otherwise stay.
  - SETUP: EN=0 and data/rs driven, for T_SETUP cycles; then EN_HIGH.
  - EN_HIGH: EN=1 for T_EN cycles; then HOLD.
  - HOLD: EN=0 with data/rs unchanged, for T_HOLD cycles; then EXEC_WAIT.
  - EXEC_WAIT: wait T_EXEC_LONG if RS=0 and data[7:2]==0, else T_EXEC. Then return to INIT (next idx) or IDLE.
- o_lcd_data/o_lcd_rs change only on entry to SETUP. They hold their value through IDLE.
- Latency: a byte accepted at edge k into an empty FIFO with FSM in IDLE is popped at edge k+1. SETUP occupies cycles k+1 to k+T_SETUP. EN rises at edge k+1+T_SETUP.
- Per-byte cost: 1 + T_SETUP + T_EN + T_HOLD + wait cycles.
- o_lcd_on follows i_on with 1 cycle latency and is independent of the FSM.
- All counters must be wide enough for the largest parameter. Counters never wrap inside a phase.

Test Plan:
All scenarios use overrides T_PWRUP=20, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=40.
- Reset with INIT_EN=1 -> EN stays 0 for 20 cycles. Then 4 EN pulses, each 4 cycles high, carrying 0x38, 0x0C, 0x01, 0x06 with RS=0. Gap after 0x01 is 40 wait cycles, other gaps 10. o_init_done rises on entry to IDLE.
- INIT_EN=0, after init: push (rs=1, 0x41) at edge k -> o_lcd_data=0x41 and RS=1 from k+1. EN high for edges k+3..k+7. o_busy drops after the 10-cycle wait.
- Push 6 bytes back-to-back with FIFO_DEPTH=4 -> o_wr_rdy deasserts at level 4. Overflow bytes are not sent. Accepted bytes appear on the LCD in order.
- Push command 0x01 then data 0x42 -> wait after 0x01 is 40 cycles, after 0x42 is 10 cycles.
- Assert reset while EN=1 -> o_lcd_en=0, o_level=0 and o_init_done=0 immediately. The power-up sequence repeats after release.
- Toggle i_on 0→1→0 during a transfer -> o_lcd_on tracks with 1-cycle delay. The EN pulse timing is unaffected.
